running_average: RTL and testbench
==================================

# running_average

Streaming moving-average filter: every clock it accepts one unsigned sample and outputs the floor mean of the most recent N samples. It sits inline on a sample stream with no input handshake; a sample is consumed on every rising clock edge outside reset. `valid` marks the point where the window first holds N real samples.

## Interface
- `N`, default 4: window length. Must be a power of two and ≥ 2. Elaboration fails otherwise.
- `DATA_W`, default 16: sample and average width.
- `clk`  in  1: single clock, rising-edge active.
- `rst_n`  in  1: asynchronous, active-low reset. Assertion takes effect immediately. Deassertion is synchronised to `clk` by the integrator.
- `data_in`  in  DATA_W: unsigned sample, captured on every rising edge while `rst_n` = 1.
- `avg_out`  out  DATA_W: registered floor(sum of window / N).
- `valid`  out  1: registered. High once N samples have been captured since reset, then stays high.

## Operation
- Window: an N-deep shift register of samples. Each capture shifts in `data_in` and drops the oldest entry. Reset clears every entry to 0.
- Running sum: a register `SUM_W = DATA_W + log2(N)` bits wide, so it cannot overflow.
  - Each capture: `sum_next = sum + data_in − oldest`, where `oldest` is the entry being dropped (0 while filling).
  - The sum is not recomputed from the window.
- Average: `avg_out <= sum_next >> log2(N)`, a truncating divide with no rounding.
- Fill counter: counts captures from 0 up to N−1, then saturates.
- State machine, 2-bit encoding:
  - FILL (reset state): `valid` = 0 and `avg_out` is held at 0. The capture that brings the sample count to N moves to RUN and loads `valid` = 1 and the first average on the same edge.
  - RUN: `avg_out` updates on every edge. `valid` = 1.
  - No exit from RUN except reset.
- All arithmetic is unsigned.
- Reset mid-operation clears the window, sum, counter and outputs, and returns to FILL. The next N captures refill the window before `valid` rises again.
- An X or undriven `data_in` while in reset is ignored.

## Timing
- Reset values: `avg_out` = 0, `valid` = 0, state = FILL, sum = 0, window all 0.
- Latency: one cycle. The `avg_out` value loaded at edge k covers the samples captured at edges k−N+1 … k.
- First valid output: at the Nth rising edge after `rst_n` deassertion. `valid` and the correct `avg_out` appear together on that edge.
- Throughput: one sample in and one average out per cycle, with no stalls.
- Wrap-around: the sample dropped at capture k is the one captured at edge k−N.

## Structure
- Package `running_average_pkg`:
  - State enum `ra_state_t` {FILL, RUN}.
  - Helper function `clog2`-based constants (`SUM_W`).
  - Default `DATA_W`.
- Sub-module `ra_sample_window`, parameterised by N and DATA_W.
  - Inputs: shift enable, data in.
  - Outputs: the oldest sample and a full flag.
  - Reset is asynchronous and active-low.
- Top level contains:
  - the sum register and subtract/add path
  - the shift divide
  - the counter
  - the FSM
  - the output registers

## Test plan
- Reset: hold `rst_n` = 0 with X on `data_in` → `avg_out` = 0 and `valid` = 0 throughout reset.
- Fill, N = 4: samples 4, 9, 2, 9 on consecutive edges → `valid` = 0 on edges 1–3. On edge 4, `valid` = 1 and `avg_out` = 6.
- Sliding window: continue with 2, 2, 9, 2, then hold 2 → `avg_out` sequence 5, 3, 5, 3, 3, 3, 2, 2. `valid` stays 1.
- Truncation and full scale:
  - Samples 1, 1, 1, 0 → `avg_out` = 0, since floor(3/4) = 0.
  - Four samples of 0xFFFF → `avg_out` = 0xFFFF, with no overflow.
- Mid-stream reset: assert `rst_n` for 1 cycle during RUN, then feed 8, 8, 8, 8 → `valid` drops immediately and returns on the 4th post-reset edge with `avg_out` = 8. No pre-reset samples contribute.
- Parameter sweep: N = 2 and N = 8 with random stimulus, compared against a reference model of the floor mean of the last N samples → exact match every cycle once `valid` = 1.

Source files
------------

// File: rtl/running_average_pkg.sv
// Shared types and elaboration helpers for the running_average moving-average filter.
// Keeps state encoding and width arithmetic in one place for the top and its users.
package running_average_pkg;

  typedef enum logic [1:0] {
    FILL = 2'b00,
    RUN  = 2'b01
  } ra_state_t;

  localparam int unsigned DefaultDataW = 16;

  // Running sum needs log2(N) extra bits so N full-scale samples never overflow.
  function automatic int unsigned sum_width(input int unsigned n, input int unsigned data_w);
    return data_w + $clog2(n);
  endfunction

  function automatic bit valid_window(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/running_average_if.sv
// Sample stream in, registered average and valid out.
// master drives samples and observes results; slave is the filter side.
interface running_average_if
  import running_average_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
);

  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] avg_out;
  logic              valid;

  modport master (
    output data_in,
    input  avg_out,
    input  valid
  );

  modport slave (
    input  data_in,
    output avg_out,
    output valid
  );

endinterface

// File: rtl/ra_sample_window.sv
// N-deep sample shift register; exposes the entry about to be dropped and whether it is real.
// An occupancy shift register tracks which slots hold samples captured since reset.
module ra_sample_window #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] oldest,
  output logic              full
);

  logic [N-1:0][DATA_W-1:0] win_q;
  logic [N-1:0]             occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      occ_q <= '0;
    end else if (shift_en) begin
      win_q <= {win_q[N-2:0], data_in};
      occ_q <= {occ_q[N-2:0], 1'b1};
    end
  end

  assign oldest = win_q[N-1];
  // High when the slot being shifted out holds a sample captured since reset.
  assign full   = occ_q[N-1];

endmodule

// File: rtl/running_average.sv
// Streaming floor-mean filter over the last N samples, one sample in and one average out per clock.
// Keeps an incremental running sum; valid rises with the first full-window average.
module running_average
  import running_average_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input logic               clk,
  input logic               rst_n,
  running_average_if.slave  bus
);

  localparam int unsigned       ShiftW  = $clog2(N);
  localparam int unsigned       SumW    = sum_width(N, DATA_W);
  localparam logic [ShiftW-1:0] LastCnt = ShiftW'(N - 1);

  if (!valid_window(N)) begin : gen_bad_n
    $error("running_average: N must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] oldest;
  logic              window_full;
  logic [SumW-1:0]   drop;
  logic [SumW-1:0]   sum_q, sum_d;
  logic [ShiftW-1:0] cnt_q, cnt_d;
  ra_state_t         state_q, state_d;
  logic [DATA_W-1:0] avg_calc;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              valid_q, valid_d;

  // Every edge outside reset is a capture, so the window always shifts.
  ra_sample_window #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (1'b1),
    .data_in  (bus.data_in),
    .oldest   (oldest),
    .full     (window_full)
  );

  always_comb begin
    drop     = window_full ? SumW'(oldest) : '0;
    sum_d    = sum_q + SumW'(bus.data_in) - drop;
    avg_calc = DATA_W'(sum_d >> ShiftW);
    cnt_d    = (cnt_q == LastCnt) ? cnt_q : cnt_q + ShiftW'(1);
  end

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    avg_d   = '0;
    unique case (state_q)
      FILL: begin
        // The Nth capture loads valid and the first average on the same edge.
        if (cnt_q == LastCnt) begin
          state_d = RUN;
          valid_d = 1'b1;
          avg_d   = avg_calc;
        end
      end
      RUN: begin
        valid_d = 1'b1;
        avg_d   = avg_calc;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cnt_q   <= '0;
      state_q <= FILL;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
    end
  end

  assign bus.avg_out = avg_q;
  assign bus.valid   = valid_q;

endmodule

// File: tb/tb_running_average.sv
// Scoreboard bench: one sample stream feeds filters with N = 2, 4 and 8; a queue-based floor-mean
// model pushes expectations at stimulus time and a monitor pops and compares after each edge.
module tb_running_average;

  localparam int unsigned DW = 16;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] a;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sample;

  always #5 clk = ~clk;

  running_average_if #(.DATA_W(DW)) if2 ();
  running_average_if #(.DATA_W(DW)) if4 ();
  running_average_if #(.DATA_W(DW)) if8 ();

  assign if2.data_in = sample;
  assign if4.data_in = sample;
  assign if8.data_in = sample;

  running_average #(.N(2), .DATA_W(DW)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  running_average #(.N(4), .DATA_W(DW)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  running_average #(.N(8), .DATA_W(DW)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  int          checks  = 0;
  int          fails   = 0;
  int          cap_cnt = 0;
  bit          run_mon = 1'b0;
  int unsigned hist[$];
  exp_t        exp2[$];
  exp_t        exp4[$];
  exp_t        exp8[$];

  // Floor mean of the newest n samples captured since reset; not valid until n have arrived.
  function automatic exp_t model(input int n);
    exp_t            e;
    longint unsigned s;
    e = '0;
    s = 0;
    if (cap_cnt >= n) begin
      for (int i = 0; i < n; i++) s += longint'(hist[hist.size() - 1 - i]);
      e.v = 1'b1;
      e.a = DW'(s / longint'(n));
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic v, input logic [DW-1:0] a, input exp_t e);
    checks++;
    if (v !== e.v || a !== e.a) begin
      fails++;
      $display("FAIL %s @%0t: got valid=%0b avg=%0d, expected valid=%0b avg=%0d",
               name, $time, v, a, e.v, e.a);
    end
  endtask

  task automatic pop_none(input string name);
    checks++;
    fails++;
    $display("FAIL %s @%0t: output seen with no expectation queued (got 1, required 0)",
             name, $time);
  endtask

  // One cycle of stimulus at the falling edge; rst=0 holds the filter in reset for this cycle.
  task automatic step(input bit rst, input logic [DW-1:0] smp);
    @(negedge clk);
    if (!rst) begin
      bit was_running;
      was_running = rst_n;
      rst_n   = 1'b0;
      sample  = 'x;
      hist.delete();
      cap_cnt = 0;
      if (was_running) begin
        // Asynchronous clear must show before the next edge.
        #1;
        cmp("async_clear_n2", if2.valid, if2.avg_out, '0);
        cmp("async_clear_n4", if4.valid, if4.avg_out, '0);
        cmp("async_clear_n8", if8.valid, if8.avg_out, '0);
      end
    end else begin
      rst_n  = 1'b1;
      sample = smp;
      hist.push_back(int'(smp));
      if (hist.size() > 8) void'(hist.pop_front());
      cap_cnt++;
    end
    exp2.push_back(model(2));
    exp4.push_back(model(4));
    exp8.push_back(model(8));
    run_mon = 1'b1;
  endtask

  always @(posedge clk) begin
    if (run_mon) begin
      #1;
      if (exp2.size() == 0) pop_none("n2_queue");
      else cmp("n2", if2.valid, if2.avg_out, exp2.pop_front());
      if (exp4.size() == 0) pop_none("n4_queue");
      else cmp("n4", if4.valid, if4.avg_out, exp4.pop_front());
      if (exp8.size() == 0) pop_none("n8_queue");
      else cmp("n8", if8.valid, if8.avg_out, exp8.pop_front());
    end
  end

  int unsigned directed [20] = '{4, 9, 2, 9, 2, 2, 9, 2, 2, 2, 2, 2,
                                 1, 1, 1, 0, 65535, 65535, 65535, 65535};

  initial begin
    sample = 'x;
    repeat (3) step(1'b0, 'x);

    // Fill, sliding window, truncation and full-scale runs.
    foreach (directed[i]) step(1'b1, DW'(directed[i]));

    // Single-cycle reset during RUN, then refill with a constant.
    step(1'b0, 'x);
    repeat (10) step(1'b1, DW'(8));

    // Random samples biased towards full scale, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      bit            r;
      logic [DW-1:0] s;
      r = ($urandom_range(0, 39) != 0);
      s = ($urandom_range(0, 3) == 0) ? {DW{1'b1}} : DW'($urandom);
      step(r, s);
    end
    repeat (12) step(1'b1, DW'($urandom));

    @(posedge clk);
    #2;
    run_mon = 1'b0;
    checks++;
    if (exp2.size() + exp4.size() + exp8.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0",
               exp2.size() + exp4.size() + exp8.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
